// File: rtl/mtc_sl_link_tx.sv
// rtl/mtc_sl_link_tx.sv - MTC-to-SL transmit link: per-channel FIFOs, round-robin arbiter, beat serialiser
// Ports: clock, rst (synchronous, active-high); mtc = flattened channel words (MSB of each word is data_valid);
//        out_data/out_valid/out_ready/out_sof/out_eof = beat stream toward the sector-logic link;
//        fifo_empty = per-channel FIFO empty flags; drop_count = saturating count of words lost to full FIFOs.
// Option: define MTC_SL_LINK_TX_HEADER_EN to prepend a header beat {seq[7:0], channel[7:0]} to every word.

package mtc_sl_pkg;
    localparam int MTC2SL_LEN = 40;
endpackage

module mtc_sl_link_tx #(
    parameter int MTC2SL_LEN    = mtc_sl_pkg::MTC2SL_LEN,
    parameter int n_PRIMARY_MTC = 3,
    parameter int LINK_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                clock,
    input  logic                                rst,
    input  logic [MTC2SL_LEN*n_PRIMARY_MTC-1:0] mtc,
    output logic [LINK_WIDTH-1:0]               out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_sof,
    output logic                                out_eof,
    output logic [n_PRIMARY_MTC-1:0]            fifo_empty,
    output logic [15:0]                         drop_count
);
    localparam int N_BEATS = (MTC2SL_LEN + LINK_WIDTH - 1) / LINK_WIDTH;
    localparam int PW      = N_BEATS * LINK_WIDTH;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int CW      = (n_PRIMARY_MTC > 1) ? $clog2(n_PRIMARY_MTC) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(n_PRIMARY_MTC - 1);

`ifdef MTC_SL_LINK_TX_HEADER_EN
    typedef enum logic [1:0] {IDLE, HDR, SEND} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    state_t                  state_q, state_d;
    logic [MTC2SL_LEN-1:0]   mem_q [n_PRIMARY_MTC][FIFO_DEPTH];
    logic [MTC2SL_LEN-1:0]   mem_d [n_PRIMARY_MTC][FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]             wr_q [n_PRIMARY_MTC];
    logic [AW:0]             wr_d [n_PRIMARY_MTC];
    logic [AW:0]             rd_q [n_PRIMARY_MTC];
    logic [AW:0]             rd_d [n_PRIMARY_MTC];
    logic [PW-1:0]           sh_q, sh_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [CW-1:0]           rr_q, rr_d;
    logic [CW-1:0]           grant_q, grant_d;
    logic [LINK_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_sof_q, out_sof_d;
    logic                    out_eof_q, out_eof_d;
    logic [15:0]             drop_q, drop_d;
`ifdef MTC_SL_LINK_TX_HEADER_EN
    logic [7:0]              seq_q [n_PRIMARY_MTC];
    logic [7:0]              seq_d [n_PRIMARY_MTC];
`endif

    logic [n_PRIMARY_MTC-1:0] empty, full;
    logic [MTC2SL_LEN-1:0]    word_v;
    logic [16:0]              drop_sum;
    logic                     found;
    int                       sidx;
    logic [CW-1:0]            gsel;

    // Flags come from registered pointers only, so a pop never frees space for a same-cycle push.
    always_comb begin
        for (int i = 0; i < n_PRIMARY_MTC; i++) begin
            empty[i] = (wr_q[i] == rd_q[i]);
            full[i]  = (wr_q[i][AW] != rd_q[i][AW]) && (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        sh_d        = sh_q;
        beat_d      = beat_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
`ifdef MTC_SL_LINK_TX_HEADER_EN
        seq_d       = seq_q;
`endif
        word_v      = '0;
        drop_sum    = {1'b0, drop_q};
        found       = 1'b0;
        sidx        = 0;
        gsel        = '0;

        // Write side: every flagged word is either stored or counted as a drop.
        for (int i = 0; i < n_PRIMARY_MTC; i++) begin
            word_v = mtc[i*MTC2SL_LEN +: MTC2SL_LEN];
            if (word_v[MTC2SL_LEN-1]) begin
                if (full[i]) begin
                    drop_sum = drop_sum + 17'd1;
                end else begin
                    mem_d[i][wr_q[i][AW-1:0]] = word_v;
                    wr_d[i] = wr_q[i] + 1'b1;
                end
            end
        end
        drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
                out_eof_d   = 1'b0;
                out_data_d  = '0;
                // First non-empty channel at or above the RR pointer, wrapping.
                for (int k = 0; k < n_PRIMARY_MTC; k++) begin
                    sidx = int'(rr_q) + k;
                    if (sidx >= n_PRIMARY_MTC) sidx = sidx - n_PRIMARY_MTC;
                    if (!found && !empty[sidx]) begin
                        found = 1'b1;
                        gsel  = CW'(sidx);
                    end
                end
                if (found) begin
                    grant_d     = gsel;
                    rd_d[gsel]  = rd_q[gsel] + 1'b1;
                    sh_d        = PW'(mem_q[gsel][rd_q[gsel][AW-1:0]]);
                    beat_d      = '0;
                    out_valid_d = 1'b1;
                    out_sof_d   = 1'b1;
`ifdef MTC_SL_LINK_TX_HEADER_EN
                    state_d     = HDR;
                    out_data_d  = LINK_WIDTH'({seq_q[gsel], 8'(gsel)});
                    out_eof_d   = 1'b0;
                    seq_d[gsel] = seq_q[gsel] + 8'd1;
`else
                    state_d     = SEND;
                    out_data_d  = sh_d[LINK_WIDTH-1:0];
                    out_eof_d   = (LAST_BEAT == '0);
`endif
                end
            end
`ifdef MTC_SL_LINK_TX_HEADER_EN
            HDR: begin
                if (out_ready) begin
                    state_d    = SEND;
                    out_data_d = sh_q[LINK_WIDTH-1:0];
                    out_sof_d  = 1'b0;
                    out_eof_d  = (LAST_BEAT == '0);
                end
            end
`endif
            SEND: begin
                if (out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        // Word done: drop to IDLE for one bubble cycle and move past this channel.
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_sof_d   = 1'b0;
                        out_eof_d   = 1'b0;
                        out_data_d  = '0;
                        rr_d        = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        sh_d       = sh_q >> LINK_WIDTH;
                        out_data_d = sh_d[LINK_WIDTH-1:0];
                        out_sof_d  = 1'b0;
                        out_eof_d  = (beat_d == LAST_BEAT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            beat_q      <= '0;
            rr_q        <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            drop_q      <= '0;
            for (int i = 0; i < n_PRIMARY_MTC; i++) begin
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
`ifdef MTC_SL_LINK_TX_HEADER_EN
                seq_q[i] <= '0;
`endif
            end
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            sh_q        <= sh_d;
            beat_q      <= beat_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            drop_q      <= drop_d;
`ifdef MTC_SL_LINK_TX_HEADER_EN
            seq_q       <= seq_d;
`endif
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign fifo_empty = empty;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_mtc_sl_link_tx.sv
// tb/tb_mtc_sl_link_tx.sv - self-checking bench for mtc_sl_link_tx against a queue-based reference model

module tb_mtc_sl_link_tx;
    localparam int L  = 40;
    localparam int LW = 16;
    localparam int N  = 3;
    localparam int D  = 4;
    localparam int NB = (L + LW - 1) / LW;

`ifdef MTC_SL_LINK_TX_HEADER_EN
    localparam logic EXP_SOF0 = 1'b0;
`else
    localparam logic EXP_SOF0 = 1'b1;
`endif

    logic           clock = 1'b0;
    logic           rst;
    logic [L*N-1:0] mtc;
    logic [LW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_sof;
    logic           out_eof;
    logic [N-1:0]   fifo_empty;
    logic [15:0]    drop_count;

    always #5 clock = ~clock;

    mtc_sl_link_tx #(
        .MTC2SL_LEN(L), .n_PRIMARY_MTC(N), .LINK_WIDTH(LW), .FIFO_DEPTH(D)
    ) dut (
        .clock(clock), .rst(rst), .mtc(mtc),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof),
        .fifo_empty(fifo_empty), .drop_count(drop_count)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [LW-1:0] data;
        logic          sof;
        logic          eof;
    } beat_t;

    logic [L-1:0] mq [N][$];
    beat_t        bq [$];
    int           rr_m = 0;
    int           grant_m = 0;
    int           drops_m = 0;
    int           seq_m [N];
    bit           chk_en = 1'b0;

    task automatic load_word(input int c, input logic [L-1:0] w);
        logic [63:0] wv;
        beat_t b;
        wv = 64'(w);
`ifdef MTC_SL_LINK_TX_HEADER_EN
        b.data = LW'({8'(seq_m[c]), 8'(c)});
        b.sof  = 1'b1;
        b.eof  = 1'b0;
        bq.push_back(b);
        seq_m[c] = (seq_m[c] + 1) % 256;
`endif
        for (int k = 0; k < NB; k++) begin
            b.data = LW'(wv >> (k * LW));
            b.sof  = (k == 0) ? EXP_SOF0 : 1'b0;
            b.eof  = (k == NB - 1);
            bq.push_back(b);
        end
    endtask

    always @(posedge clock) begin : model
        int sz [N];
        int c;
        logic [L-1:0] w;
        for (int i = 0; i < N; i++) sz[i] = mq[i].size();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                seq_m[i] = 0;
            end
            bq.delete();
            rr_m = 0;
            grant_m = 0;
            drops_m = 0;
        end else begin
            if (bq.size() != 0) begin
                if (out_ready) begin
                    void'(bq.pop_front());
                    if (bq.size() == 0) rr_m = (grant_m + 1) % N;
                end
            end else begin
                c = -1;
                for (int k = 0; k < N; k++)
                    if (c < 0 && sz[(rr_m + k) % N] != 0) c = (rr_m + k) % N;
                if (c >= 0) begin
                    grant_m = c;
                    w = mq[c].pop_front();
                    load_word(c, w);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (mtc[i*L + L - 1]) begin
                    if (sz[i] >= D) begin
                        if (drops_m < 65535) drops_m++;
                    end else begin
                        mq[i].push_back(mtc[i*L +: L]);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [N-1:0] fe;
        if (chk_en) begin
            for (int i = 0; i < N; i++) fe[i] = (mq[i].size() == 0);
            check("m_valid", 64'(out_valid), 64'(bq.size() != 0));
            if (bq.size() != 0) begin
                check("m_data", 64'(out_data), 64'(bq[0].data));
                check("m_sof", 64'(out_sof), 64'(bq[0].sof));
                check("m_eof", 64'(out_eof), 64'(bq[0].eof));
            end
            check("m_empty", 64'(fifo_empty), 64'(fe));
            check("m_drop", 64'(drop_count), 64'(drops_m));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        mtc = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_sof(output logic [LW-1:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (out_valid && out_sof) begin
                d  = out_data;
                ok = 1'b1;
            end
            step();
        end
    endtask

    function automatic logic [LW-1:0] first_id(input int ch, input logic [L-1:0] w);
`ifdef MTC_SL_LINK_TX_HEADER_EN
        return LW'(ch);
`else
        return w[LW-1:0];
`endif
    endfunction

    function automatic logic [L-1:0] rword(input bit v);
        logic [L-1:0] w;
        w = L'({$urandom(), $urandom()});
        w[L-1] = v;
        return w;
    endfunction

    logic [L-1:0]  rw [N];
    logic [LW-1:0] got;
    bit            ok;

    initial begin
        rst = 1'b1;
        mtc = '0;
        out_ready = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_empty", 64'(fifo_empty), 64'h7);
        check("rst_drop", 64'(drop_count), 64'd0);
        rst = 1'b0;

        // single word on channel 1
        mtc[1*L +: L] = 40'hC1_2345_6789;
        step();
        mtc = '0;
        step();
`ifdef MTC_SL_LINK_TX_HEADER_EN
        check("sw_hdr", 64'(out_data), 64'h0001);
        check("sw_hdr_sof", 64'(out_sof), 64'd1);
        step();
`endif
        check("sw_b0", 64'(out_data), 64'h6789);
        check("sw_b0_sof", 64'(out_sof), 64'(EXP_SOF0));
        check("sw_b0_valid", 64'(out_valid), 64'd1);
        step();
        check("sw_b1", 64'(out_data), 64'h2345);
        step();
        check("sw_b2", 64'(out_data), 64'h00C1);
        check("sw_b2_eof", 64'(out_eof), 64'd1);
        step();
        check("sw_valid_end", 64'(out_valid), 64'd0);
        check("sw_empty", 64'(fifo_empty), 64'h7);

`ifdef MTC_SL_LINK_TX_HEADER_EN
        // two words on channel 2: sequence numbers 0 then 1
        reset_dut();
        mtc[2*L +: L] = 40'h80_0000_0A0A;
        step();
        mtc[2*L +: L] = 40'h80_0000_0B0B;
        step();
        mtc = '0;
        check("hdr_seq0", 64'(out_data), 64'h0002);
        check("hdr_seq0_sof", 64'(out_sof), 64'd1);
        repeat (5) step();
        check("hdr_seq1", 64'(out_data), 64'h0102);
        check("hdr_seq1_sof", 64'(out_sof), 64'd1);
        repeat (6) step();
`endif

        // round-robin: three channels in one cycle
        reset_dut();
        rw[0] = 40'h80_0000_1110;
        rw[1] = 40'h80_0000_2221;
        rw[2] = 40'h80_0000_3332;
        mtc = {rw[2], rw[1], rw[0]};
        step();
        mtc = '0;
        for (int i = 0; i < N; i++) begin
            wait_sof(got, ok);
            check("rr_timeout", 64'(ok), 64'd1);
            check("rr_order", 64'(got), 64'(first_id(i, rw[i])));
        end
        repeat (8) step();
        // pointer back at 0: channel 0 must beat channel 2
        mtc = {rw[2], {L{1'b0}}, rw[0]};
        step();
        mtc = '0;
        wait_sof(got, ok);
        check("rr_wrap_timeout", 64'(ok), 64'd1);
        check("rr_wrap", 64'(got), 64'(first_id(0, rw[0])));
        repeat (20) step();

        // backpressure on beat 1
        reset_dut();
        mtc[L-1:0] = 40'hAB_CDEF_1234;
        step();
        mtc = '0;
        ok = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
            if (out_valid && out_data == 16'hCDEF) ok = 1'b1;
            else step();
        end
        check("bp_reach", 64'(ok), 64'd1);
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            step();
            check("bp_hold_data", 64'(out_data), 64'hCDEF);
            check("bp_hold_flags", 64'({out_valid, out_sof, out_eof}), 64'b100);
        end
        out_ready = 1'b1;
        step();
        check("bp_last", 64'(out_data), 64'h00AB);
        check("bp_last_eof", 64'(out_eof), 64'd1);
        repeat (4) step();

        // overflow of channel 0 with the link stalled
        reset_dut();
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            mtc = '0;
            mtc[L-1:0] = 40'h80_0000_0000 | 40'(k + 1);
            step();
        end
        mtc = '0;
        check("ovf_drop", 64'(drop_count), 64'd2);
        check("ovf_valid", 64'(out_valid), 64'd1);
        check("ovf_sof", 64'(out_sof), 64'd1);
        check("ovf_empty", 64'(fifo_empty), 64'b110);
        out_ready = 1'b1;
        repeat (40) step();

        // reset in the middle of a word with other channels queued
        mtc = {40'h80_0000_0C0C, 40'h80_0000_0B0B, 40'h80_0000_0A0A};
        step();
        mtc = '0;
        ok = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
            if (out_valid && !out_sof && !out_eof) ok = 1'b1;
            else step();
        end
        check("mid_reach", 64'(ok), 64'd1);
        rst = 1'b1;
        step();
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_eof", 64'(out_eof), 64'd0);
        check("mid_empty", 64'(fifo_empty), 64'h7);
        check("mid_drop", 64'(drop_count), 64'd0);
        rst = 1'b0;
        repeat (3) step();

        // randomized traffic with random backpressure
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) mtc[i*L +: L] = rword($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        mtc = '0;
        out_ready = 1'b1;
        repeat (60) step();

        // drop counter saturation: stalled link, all channels flooding
        out_ready = 1'b0;
        for (int t = 0; t < 22100; t++) begin
            for (int i = 0; i < N; i++) mtc[i*L +: L] = rword(1'b1);
            step();
        end
        mtc = '0;
        check("sat_drop", 64'(drop_count), 64'hFFFF);
        out_ready = 1'b1;
        repeat (60) step();
        check("drain_empty", 64'(fifo_empty), 64'h7);
        check("drain_valid", 64'(out_valid), 64'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
